// File: rtl/lane_deskew_ctrl.sv
// Deskew controller: timestamps per-lane AM arrival and programs each lane FIFO's compensating delay.
// Latency: strobe and delays one valid cycle after the last lane's AM; read enable/lock one valid cycle later.
// Backpressure: none; i_valid is a clock enable and every register (pulses included) holds on i_valid=0.
module lane_deskew_ctrl #(
    parameter int N_LANES        = 20,
    parameter int FIFO_DEPTH     = 20,
    parameter int NB_DELAY_COUNT = $clog2(FIFO_DEPTH),
    parameter int MAX_SKEW       = 16,
    parameter int NB_SKEW_CNT    = $clog2(MAX_SKEW + 1)
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_valid,
    input  logic                              i_enable,
    input  logic                              i_resync,
    input  logic [N_LANES-1:0]                i_am_flag,
    output logic [N_LANES-1:0]                o_set_fifo_delay,
    output logic [N_LANES*NB_DELAY_COUNT-1:0] o_read_addr,
    output logic                              o_read_enb,
    output logic                              o_deskew_done,
    output logic                              o_invalid_skew
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_COUNT,
        ST_SET,
        ST_LOCKED
    } state_t;

    localparam logic [NB_SKEW_CNT-1:0] SKEW_LIMIT = NB_SKEW_CNT'(MAX_SKEW);
    localparam logic [NB_SKEW_CNT-1:0] CNT_ONE    = NB_SKEW_CNT'(1);

    state_t                            state_q, state_d;
    logic [NB_SKEW_CNT-1:0]            counter_q, counter_d;
    logic [N_LANES-1:0]                arrived_q, arrived_d, arrived_cap;
    logic [NB_SKEW_CNT-1:0]            arrival_q   [N_LANES];
    logic [NB_SKEW_CNT-1:0]            arrival_d   [N_LANES];
    logic [NB_SKEW_CNT-1:0]            arrival_cap [N_LANES];
    logic [NB_SKEW_CNT-1:0]            last_arrival;
    logic [N_LANES*NB_DELAY_COUNT-1:0] delay_vec;

    logic [N_LANES-1:0]                set_d;
    logic [N_LANES*NB_DELAY_COUNT-1:0] addr_d;
    logic                              enb_d, done_d, inv_d;

    // Arrival capture including this cycle's flags; only first flags from a lane are timestamped.
    always_comb begin
        arrived_cap = arrived_q;
        arrival_cap = arrival_q;
        if (state_q == ST_WAIT_FIRST) begin
            arrived_cap = i_am_flag;
            for (int k = 0; k < N_LANES; k++) begin
                if (i_am_flag[k]) begin
                    arrival_cap[k] = '0;
                end
            end
        end else if (state_q == ST_COUNT) begin
            for (int k = 0; k < N_LANES; k++) begin
                if (i_am_flag[k] && !arrived_q[k]) begin
                    arrived_cap[k] = 1'b1;
                    arrival_cap[k] = counter_q;
                end
            end
        end
    end

    always_comb begin
        last_arrival = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (arrival_cap[k] > last_arrival) begin
                last_arrival = arrival_cap[k];
            end
        end
    end

    // Latest lane gets zero delay; earlier lanes are held back by how much sooner they arrived.
    always_comb begin
        logic [NB_SKEW_CNT-1:0] diff;
        diff      = '0;
        delay_vec = '0;
        for (int k = 0; k < N_LANES; k++) begin
            diff = last_arrival - arrival_cap[k];
            delay_vec[k*NB_DELAY_COUNT +: NB_DELAY_COUNT] = NB_DELAY_COUNT'(diff);
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        arrived_d = arrived_q;
        arrival_d = arrival_q;
        set_d     = '0;
        addr_d    = o_read_addr;
        enb_d     = o_read_enb;
        done_d    = o_deskew_done;
        inv_d     = 1'b0;

        if (!i_enable) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            arrived_d = '0;
            arrival_d = '{default: '0};
            addr_d    = '0;
            enb_d     = 1'b0;
            done_d    = 1'b0;
        end else if (i_resync) begin
            state_d   = ST_WAIT_FIRST;
            counter_d = '0;
            arrived_d = '0;
            arrival_d = '{default: '0};
            addr_d    = '0;
            enb_d     = 1'b0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (|i_am_flag) begin
                        arrived_d = arrived_cap;
                        arrival_d = arrival_cap;
                        counter_d = CNT_ONE;
                        if (&arrived_cap) begin
                            state_d = ST_SET;
                            set_d   = '1;
                            addr_d  = delay_vec;
                        end else begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    arrived_d = arrived_cap;
                    arrival_d = arrival_cap;
                    counter_d = counter_q + CNT_ONE;
                    if (&arrived_cap) begin
                        state_d = ST_SET;
                        set_d   = '1;
                        addr_d  = delay_vec;
                    end else if (counter_q >= SKEW_LIMIT) begin
                        // Spread too large: drop everything, flags on this cycle are not a new first arrival.
                        state_d   = ST_WAIT_FIRST;
                        counter_d = '0;
                        arrived_d = '0;
                        arrival_d = '{default: '0};
                        inv_d     = 1'b1;
                    end
                end
                ST_SET: begin
                    state_d = ST_LOCKED;
                    enb_d   = 1'b1;
                    done_d  = 1'b1;
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else if (i_valid) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            counter_q        <= '0;
            arrived_q        <= '0;
            arrival_q        <= '{default: '0};
            o_set_fifo_delay <= '0;
            o_read_addr      <= '0;
            o_read_enb       <= 1'b0;
            o_deskew_done    <= 1'b0;
            o_invalid_skew   <= 1'b0;
        end else if (i_valid) begin
            counter_q        <= counter_d;
            arrived_q        <= arrived_d;
            arrival_q        <= arrival_d;
            o_set_fifo_delay <= set_d;
            o_read_addr      <= addr_d;
            o_read_enb       <= enb_d;
            o_deskew_done    <= done_d;
            o_invalid_skew   <= inv_d;
        end
    end

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Directed bench for lane_deskew_ctrl: each scenario task drives vectors and checks the whole
// output bundle {set, addr, read_enb, done, invalid_skew} against hand-computed values.
module tb_lane_deskew_ctrl;
    localparam int N  = 20;
    localparam int DW = 5;
    localparam int OW = N + N*DW + 3;

    logic            i_clock  = 1'b0;
    logic            i_reset  = 1'b0;
    logic            i_valid  = 1'b1;
    logic            i_enable = 1'b0;
    logic            i_resync = 1'b0;
    logic [N-1:0]    i_am_flag = '0;
    logic [N-1:0]    o_set_fifo_delay;
    logic [N*DW-1:0] o_read_addr;
    logic            o_read_enb;
    logic            o_deskew_done;
    logic            o_invalid_skew;

    always #5 i_clock = ~i_clock;

    lane_deskew_ctrl #(
        .N_LANES(N), .FIFO_DEPTH(20), .NB_DELAY_COUNT(DW), .MAX_SKEW(16), .NB_SKEW_CNT(5)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_enable(i_enable),
        .i_resync(i_resync), .i_am_flag(i_am_flag), .o_set_fifo_delay(o_set_fifo_delay),
        .o_read_addr(o_read_addr), .o_read_enb(o_read_enb), .o_deskew_done(o_deskew_done),
        .o_invalid_skew(o_invalid_skew)
    );

    logic [OW-1:0]   obs;
    logic [OW-1:0]   exp;
    logic [N*DW-1:0] spread_addr;
    logic [N*DW-1:0] resync_addr;
    logic [N-1:0]    zero_set;
    logic [N*DW-1:0] zero_addr;
    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {o_set_fifo_delay, o_read_addr, o_read_enb, o_deskew_done, o_invalid_skew};

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    function automatic logic [OW-1:0] exp_out(input logic [N-1:0] s, input logic [N*DW-1:0] a,
                                              input logic enb, input logic done, input logic inv);
        return {s, a, enb, done, inv};
    endfunction

    // Lane 0 at t0, lane 5 at t0+3 (lane 0 repeats then), lane 19 at t0+9, the rest at t0+2.
    function automatic logic [N-1:0] spread_flags(input int c);
        logic [N-1:0] f;
        f = '0;
        case (c)
            0: f[0] = 1'b1;
            2: begin f = '1; f[0] = 1'b0; f[5] = 1'b0; f[19] = 1'b0; end
            3: begin f[5] = 1'b1; f[0] = 1'b1; end
            9: f[19] = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    task automatic test_reset();
        i_reset = 1'b0; i_enable = 1'b0; i_am_flag = '1;
        repeat (3) tick();
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, exp); end
        i_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL idle_disabled[%0d]: got %h expected %h", i, obs, exp); end
        end
        i_am_flag = '0;
    endtask

    task automatic test_zero_skew();
        i_enable = 1'b1;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL zero_wait: got %h expected %h", obs, exp); end
        i_am_flag = '1;
        tick();
        exp = exp_out('1, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL zero_strobe: got %h expected %h", obs, exp); end
        i_am_flag = '0;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b1, 1'b1, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL zero_locked: got %h expected %h", obs, exp); end
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL zero_hold: got %h expected %h", obs, exp); end
    endtask

    task automatic test_spread();
        i_enable = 1'b0;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL spread_disable: got %h expected %h", obs, exp); end
        i_enable = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            i_am_flag = spread_flags(c);
            tick();
            if (c < 9) exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
            else       exp = exp_out('1, spread_addr, 1'b0, 1'b0, 1'b0);
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL spread_c%0d: got %h expected %h", c, obs, exp); end
        end
        i_am_flag = '0;
        tick();
        exp = exp_out(zero_set, spread_addr, 1'b1, 1'b1, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL spread_locked: got %h expected %h", obs, exp); end
        i_am_flag = '1;
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL spread_locked_hold: got %h expected %h", obs, exp); end
        i_am_flag = '0;
    endtask

    task automatic test_valid_gaps();
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1; i_am_flag = spread_flags(c);
            tick();
            // Garbage flags on a non-valid cycle must be ignored and outputs must hold.
            i_valid = 1'b0; i_am_flag = '1;
            tick();
            if (c < 9) exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
            else       exp = exp_out('1, spread_addr, 1'b0, 1'b0, 1'b0);
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL gaps_c%0d: got %h expected %h", c, obs, exp); end
        end
        i_valid = 1'b1; i_am_flag = '0;
        tick();
        exp = exp_out(zero_set, spread_addr, 1'b1, 1'b1, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL gaps_locked: got %h expected %h", obs, exp); end
        i_valid = 1'b0; i_enable = 1'b0; i_resync = 1'b1;
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL gaps_invalid_hold: got %h expected %h", obs, exp); end
        i_valid = 1'b1; i_enable = 1'b1; i_resync = 1'b0;
    endtask

    task automatic test_excess_skew();
        logic [N-1:0] f;
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
        f = '1; f[19] = 1'b0;
        i_am_flag = f;
        tick();
        for (int k = 1; k <= 16; k++) begin
            i_am_flag = '0;
            if (k == 16) i_am_flag[0] = 1'b1;
            tick();
            exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, (k == 16));
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL skew_k%0d: got %h expected %h", k, obs, exp); end
        end
        i_am_flag = '0;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL skew_pulse_end: got %h expected %h", obs, exp); end
        i_am_flag = '1;
        tick();
        exp = exp_out('1, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL skew_recover_strobe: got %h expected %h", obs, exp); end
        i_am_flag = '0;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b1, 1'b1, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL skew_recover_locked: got %h expected %h", obs, exp); end
    endtask

    task automatic test_resync();
        i_resync = 1'b1; i_am_flag = '1;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL resync_clear: got %h expected %h", obs, exp); end
        i_resync = 1'b0;
        i_am_flag = '1; i_am_flag[3] = 1'b0;
        tick();
        i_am_flag = '0;
        tick();
        i_am_flag[3] = 1'b1;
        tick();
        exp = exp_out('1, resync_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL resync_strobe: got %h expected %h", obs, exp); end
        i_am_flag = '0;
        tick();
        exp = exp_out(zero_set, resync_addr, 1'b1, 1'b1, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL resync_locked: got %h expected %h", obs, exp); end
    endtask

    task automatic test_disable_mid_count();
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
        i_am_flag = '0; i_am_flag[0] = 1'b1;
        tick();
        i_am_flag = '0;
        tick();
        i_enable = 1'b0; i_am_flag = '1;
        tick();
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL disable_mid_count: got %h expected %h", obs, exp); end
        i_resync = 1'b1; i_am_flag = '0;
        tick();
        i_enable = 1'b1; i_resync = 1'b0; i_am_flag = '1;
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL enable_over_resync: got %h expected %h", obs, exp); end
        tick();
        exp = exp_out('1, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL reenable_strobe: got %h expected %h", obs, exp); end
        i_am_flag = '0;
        tick();
    endtask

    task automatic test_reset_mid_set();
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
        i_am_flag = '1;
        tick();
        exp = exp_out('1, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_pre_strobe: got %h expected %h", obs, exp); end
        i_am_flag = '0;
        #2 i_reset = 1'b0;
        #1;
        exp = exp_out(zero_set, zero_addr, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_async: got %h expected %h", obs, exp); end
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_held: got %h expected %h", obs, exp); end
        i_reset = 1'b1;
        tick();
        tick();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rst_no_lock: got %h expected %h", obs, exp); end
    endtask

    initial begin
        zero_set  = '0;
        zero_addr = '0;
        for (int k = 0; k < N; k++) begin
            spread_addr[k*DW +: DW] = 5'd7;
            resync_addr[k*DW +: DW] = 5'd2;
        end
        spread_addr[0*DW +: DW]  = 5'd9;
        spread_addr[5*DW +: DW]  = 5'd6;
        spread_addr[19*DW +: DW] = 5'd0;
        resync_addr[3*DW +: DW]  = 5'd0;

        test_reset();
        test_zero_skew();
        test_spread();
        test_valid_gaps();
        test_excess_skew();
        test_resync();
        test_disable_mid_count();
        test_reset_mid_set();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
